// File: rtl/ffd_reg_arbiter_if.sv
// Request/grant/ack bus between two requesters and the shared-register arbiter.
interface ffd_reg_arbiter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             ack_a;
    logic             ack_b;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic [CNT_W-1:0] wr_count;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  gnt_a, gnt_b, ack_a, ack_b, q, busy, wr_count
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output gnt_a, gnt_b, ack_a, ack_b, q, busy, wr_count
    );
endinterface

// File: rtl/ffd_reg_arbiter.sv
// Round-robin arbiter that sequences loads of a shared register from two requesters
// and counts completed writes.
module ffd_reg_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    ffd_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] wr_count_r;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             ack_a_r;
    logic             ack_b_r;
    logic             busy_r;
    logic             last_b;
    logic             elig_a_c;
    logic             elig_b_c;

    // A requester acked last cycle is still dropping req, so it sits out one round.
    assign elig_a_c = bus.req_a & ~ack_a_r;
    assign elig_b_c = bus.req_b & ~ack_b_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            q_r        <= '0;
            wr_count_r <= '0;
            gnt_a_r    <= 1'b0;
            gnt_b_r    <= 1'b0;
            ack_a_r    <= 1'b0;
            ack_b_r    <= 1'b0;
            busy_r     <= 1'b0;
            last_b     <= 1'b1;
        end else begin
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig_a_c && (!elig_b_c || last_b)) begin
                        state   <= GNT_A;
                        gnt_a_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else if (elig_b_c) begin
                        state   <= GNT_B;
                        gnt_b_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                GNT_A: begin
                    state   <= IDLE;
                    gnt_a_r <= 1'b0;
                    busy_r  <= 1'b0;
                    // A withdrawn request aborts: nothing loaded, no ack.
                    if (bus.req_a) begin
                        q_r        <= bus.data_a;
                        ack_a_r    <= 1'b1;
                        last_b     <= 1'b0;
                        wr_count_r <= wr_count_r + CNT_W'(1);
                    end
                end
                GNT_B: begin
                    state   <= IDLE;
                    gnt_b_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (bus.req_b) begin
                        q_r        <= bus.data_b;
                        ack_b_r    <= 1'b1;
                        last_b     <= 1'b1;
                        wr_count_r <= wr_count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_a_r <= 1'b0;
                    gnt_b_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_a    = gnt_a_r;
    assign bus.gnt_b    = gnt_b_r;
    assign bus.ack_a    = ack_a_r;
    assign bus.ack_b    = ack_b_r;
    assign bus.q        = q_r;
    assign bus.busy     = busy_r;
    assign bus.wr_count = wr_count_r;
endmodule

// File: tb/tb_ffd_reg_arbiter.sv
// Self-checking bench for ffd_reg_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbiter.
module tb_ffd_reg_arbiter;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam int          CNT_MOD = 1 << CNT_W;

    logic clk_tb;
    logic rst_n;

    ffd_reg_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    ffd_reg_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk_tb),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the grant (0 none, 1 A, 2 B), who won last, register, count, acks.
    int m_owner, m_last, m_q, m_cnt;
    bit m_ack_a, m_ack_b;

    logic [WIDTH-1:0] prev_q;
    logic             prev_ack_a, prev_ack_b;
    bit               have_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ra, input int da, input bit rb, input int db);
        int nxt;
        bit na, nb, ea, eb;
        nxt = 0; na = 0; nb = 0;
        if (!r) begin
            m_owner = 0; m_q = 0; m_cnt = 0; m_last = 2;
            m_ack_a = 0; m_ack_b = 0;
        end else begin
            if (m_owner == 0) begin
                ea = ra && !m_ack_a;
                eb = rb && !m_ack_b;
                if (ea && eb)  nxt = (m_last == 1) ? 2 : 1;
                else if (ea)   nxt = 1;
                else if (eb)   nxt = 2;
            end else if (m_owner == 1 && ra) begin
                m_q = da; na = 1; m_last = 1; m_cnt = (m_cnt + 1) % CNT_MOD;
            end else if (m_owner == 2 && rb) begin
                m_q = db; nb = 1; m_last = 2; m_cnt = (m_cnt + 1) % CNT_MOD;
            end
            m_owner = nxt; m_ack_a = na; m_ack_b = nb;
        end
    endtask

    // Per-cycle comparison of every output against the model, plus protocol invariants.
    task automatic compare(input bit r);
        chk("gnt_a",    32'(bus.gnt_a),    32'(m_owner == 1));
        chk("gnt_b",    32'(bus.gnt_b),    32'(m_owner == 2));
        chk("busy",     32'(bus.busy),     32'(m_owner != 0));
        chk("ack_a",    32'(bus.ack_a),    32'(m_ack_a));
        chk("ack_b",    32'(bus.ack_b),    32'(m_ack_b));
        chk("q",        32'(bus.q),        32'(m_q));
        chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
        chk("gnt_excl", 32'(bus.gnt_a & bus.gnt_b), 32'(0));
        chk("ack_excl", 32'(bus.ack_a & bus.ack_b), 32'(0));
        if (have_prev) begin
            chk("ack_a_1cyc", 32'(prev_ack_a & bus.ack_a), 32'(0));
            chk("ack_b_1cyc", 32'(prev_ack_b & bus.ack_b), 32'(0));
            if (r && !(bus.ack_a || bus.ack_b))
                chk("q_hold", 32'(bus.q), 32'(prev_q));
        end
        prev_q = bus.q; prev_ack_a = bus.ack_a; prev_ack_b = bus.ack_b;
        have_prev = 1;
    endtask

    task automatic step();
        bit r, ra, rb;
        int da, db;
        r = rst_n; ra = bus.req_a; rb = bus.req_b;
        da = int'(bus.data_a); db = int'(bus.data_b);
        @(posedge clk_tb);
        #1;
        model_edge(r, ra, da, rb, db);
        compare(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    string seq;
    int    k;

    initial begin
        rst_n = 1'b0;
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        bus.data_a = 4'h5; bus.data_b = 4'h6;
        m_owner = 0; m_last = 2; m_q = 0; m_cnt = 0; m_ack_a = 0; m_ack_b = 0;

        // Reset with both requests pending
        step();
        step();
        chk("t1_q",     32'(bus.q), 32'h0);
        chk("t1_busy",  32'(bus.busy), 32'h0);
        chk("t1_gnt",   32'({bus.gnt_a, bus.gnt_b}), 32'h0);
        chk("t1_cnt",   32'(bus.wr_count), 32'h0);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        rst_n = 1'b1;
        step();

        // Single request from A
        bus.req_a = 1'b1; bus.data_a = 4'hA;
        step();
        chk("t2_gnt_a", 32'(bus.gnt_a), 32'h1);
        step();
        chk("t2_ack_a", 32'(bus.ack_a), 32'h1);
        chk("t2_q",     32'(bus.q), 32'hA);
        chk("t2_cnt",   32'(bus.wr_count), 32'h1);
        bus.req_a = 1'b0;
        step();
        chk("t2_ack_drop", 32'(bus.ack_a), 32'h0);

        // Contention from reset: A first, then B
        do_reset();
        bus.req_a = 1'b1; bus.req_b = 1'b1; bus.data_a = 4'h3; bus.data_b = 4'hC;
        seq = "";
        for (int i = 0; i < 20 && (bus.req_a || bus.req_b); i++) begin
            step();
            if (bus.ack_a) begin seq = {seq, "A"}; chk("t3_qa", 32'(bus.q), 32'h3); end
            if (bus.ack_b) begin seq = {seq, "B"}; chk("t3_qb", 32'(bus.q), 32'hC); end
            if (m_ack_a) bus.req_a = 1'b0;
            if (m_ack_b) bus.req_b = 1'b0;
        end
        step();
        step();
        chk_str("t3_order", seq, "AB");
        chk("t3_final_q", 32'(bus.q), 32'hC);

        // Fairness: both keep requesting, 8 loads wrap the counter
        do_reset();
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        seq = ""; k = 0;
        for (int i = 0; i < 60 && k < 8; i++) begin
            step();
            if (bus.ack_a) begin seq = {seq, "A"}; k++; chk("t4_cnt", 32'(bus.wr_count), 32'(k % 8)); end
            if (bus.ack_b) begin seq = {seq, "B"}; k++; chk("t4_cnt", 32'(bus.wr_count), 32'(k % 8)); end
            if (m_ack_a) bus.data_a = 4'($urandom);
            if (m_ack_b) bus.data_b = 4'($urandom);
        end
        chk_str("t4_order", seq, "ABABABAB");
        chk("t4_wrap", 32'(bus.wr_count), 32'h0);

        // Abort: B withdraws during its grant
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        step();
        step();
        bus.req_a = 1'b1; bus.data_a = 4'h5;
        step();
        step();
        bus.req_a = 1'b0;
        step();
        bus.req_b = 1'b1; bus.data_b = 4'h9;
        step();
        chk("t5_gnt_b", 32'(bus.gnt_b), 32'h1);
        bus.req_b = 1'b0;
        step();
        chk("t5_no_ack", 32'(bus.ack_b), 32'h0);
        chk("t5_q_kept", 32'(bus.q), 32'h5);
        chk("t5_cnt_kept", 32'(bus.wr_count), 32'h1);

        // Reset during GNT_A: no load, and A wins the next tie
        bus.req_a = 1'b1; bus.data_a = 4'h6;
        step();
        chk("t5_gnt_a", 32'(bus.gnt_a), 32'h1);
        rst_n = 1'b0;
        step();
        chk("t5_rst_q",   32'(bus.q), 32'h0);
        chk("t5_rst_ack", 32'(bus.ack_a), 32'h0);
        rst_n = 1'b1;
        bus.req_b = 1'b1; bus.data_a = 4'h1; bus.data_b = 4'h2;
        step();
        chk("t5_tie_a", 32'(bus.gnt_a), 32'h1);
        step();
        chk("t5_tie_q", 32'(bus.q), 32'h1);

        // Random traffic, including occasional resets and data changes outside grants
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            bus.req_a = ($urandom_range(0, 3) != 0);
            bus.req_b = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) bus.data_a = 4'($urandom);
            if ($urandom_range(0, 1) == 0) bus.data_b = 4'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
